// File: rtl/float_to_fix.sv
// float_to_fix: reads an IEEE half-precision float from byte-wide data memory,
// converts it to two's-complement fix(8.8) by iterative shifting with truncation
// toward zero, and writes the 16-bit result back. Handshake: start / done.
module float_to_fix #(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 8,
    parameter int unsigned SRC_ADDR = 0,
    parameter int unsigned DST_ADDR = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] DataAddr,
    output logic          ReadMem,
    output logic          MemWrite,
    output logic [DW-1:0] DataIn,
    input  logic [DW-1:0] DataOut
);

    typedef enum logic [3:0] {
        StIdle,
        StRdLo,
        StRdHi,
        StDecode,
        StShift,
        StNeg,
        StWrLo,
        StWrHi,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] f_q, f_d;
    logic [15:0] mag_q, mag_d;
    logic [15:0] res_q, res_d;
    logic        sign_q, sign_d;
    logic        shl_q, shl_d;
    logic        shr_q, shr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    logic [4:0]  exp_w;
    logic        trap_w;

    assign exp_w  = f_q[14:10];
    // Zero/subnormal, exact -128.0 and anything too large skip the shifter.
    assign trap_w = (exp_w == 5'd0) || (exp_w >= 5'd22) ||
                    (f_q[15] && (f_q[14:0] == 15'h5800));

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (start) state_d = StRdLo;
            StRdLo:         state_d = StRdHi;
            StRdHi:         state_d = StDecode;
            StDecode:       state_d = trap_w ? StNeg : StShift;
            StShift:        if (cnt_q == 4'd1) state_d = StNeg;
            StNeg:          state_d = StWrLo;
            StWrLo:         state_d = StWrHi;
            StWrHi:         state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    // Memory-port outputs decoded from the current state.
    always_comb begin
        DataAddr = '0;
        ReadMem  = 1'b0;
        MemWrite = 1'b0;
        DataIn   = '0;
        unique case (state_q)
            StRdLo: begin
                ReadMem  = 1'b1;
                DataAddr = AW'(SRC_ADDR);
            end
            StRdHi: begin
                ReadMem  = 1'b1;
                DataAddr = AW'(SRC_ADDR + 1);
            end
            StWrLo: begin
                MemWrite = 1'b1;
                DataAddr = AW'(DST_ADDR);
                DataIn   = DW'(res_q[7:0]);
            end
            StWrHi: begin
                MemWrite = 1'b1;
                DataAddr = AW'(DST_ADDR + 1);
                DataIn   = DW'(res_q[15:8]);
            end
            default: ;
        endcase
    end

    assign done = done_q;

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_q    <= '0;
            mag_q  <= '0;
            res_q  <= '0;
            sign_q <= 1'b0;
            shl_q  <= 1'b0;
            shr_q  <= 1'b0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            f_q    <= f_d;
            mag_q  <= mag_d;
            res_q  <= res_d;
            sign_q <= sign_d;
            shl_q  <= shl_d;
            shr_q  <= shr_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Datapath next-state: load, decode, shift one bit per cycle, negate.
    always_comb begin
        f_d    = f_q;
        mag_d  = mag_q;
        res_d  = res_q;
        sign_d = sign_q;
        shl_d  = shl_q;
        shr_d  = shr_q;
        cnt_d  = cnt_q;
        // done is registered off the DONE state, so it rises one cycle after entry
        // and drops on the edge that accepts the next start.
        done_d = (state_q == StDone) && !start;
        unique case (state_q)
            StRdLo: f_d[7:0]  = DataOut[7:0];
            StRdHi: f_d[15:8] = DataOut[7:0];
            StDecode: begin
                sign_d = f_q[15];
                shl_d  = 1'b0;
                shr_d  = 1'b0;
                cnt_d  = 4'd1;
                if (exp_w == 5'd0) begin
                    mag_d  = 16'h0000;
                    sign_d = 1'b0;
                end else if (f_q[15] && (f_q[14:0] == 15'h5800)) begin
                    mag_d  = 16'h8000;
                    sign_d = 1'b0;
                end else if (exp_w >= 5'd22) begin
                    // Trap results are loaded pre-signed; NEG passes them through.
                    mag_d  = f_q[15] ? 16'h8000 : 16'h7FFF;
                    sign_d = 1'b0;
                end else begin
                    mag_d = {5'b0, 1'b1, f_q[9:0]};
                    if (exp_w > 5'd17) begin
                        shl_d = 1'b1;
                        cnt_d = 4'(exp_w - 5'd17);
                    end else if (exp_w < 5'd17) begin
                        shr_d = 1'b1;
                        // Beyond 12 right shifts the 11-bit significand is already gone.
                        cnt_d = (exp_w <= 5'd5) ? 4'd12 : 4'(5'd17 - exp_w);
                    end
                end
            end
            StShift: begin
                if (shl_q) begin
                    mag_d = {mag_q[14:0], 1'b0};
                end else if (shr_q) begin
                    mag_d = {1'b0, mag_q[15:1]};
                end
                cnt_d = cnt_q - 4'd1;
            end
            StNeg: res_d = sign_q ? (~mag_q + 16'd1) : mag_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_float_to_fix.sv
// Self-checking bench for float_to_fix: directed cases, reset abort, start held while
// busy, and 256 back-to-back random conversions against a real-arithmetic model.
module tb_float_to_fix;

    logic       clk;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] DataAddr;
    logic       ReadMem;
    logic       MemWrite;
    logic [7:0] DataIn;
    logic [7:0] DataOut;

    logic [7:0] mem [256];
    int         wr_cnt;
    int         src_wr_cnt;
    int         pass_cnt;
    int         total_cnt;

    float_to_fix #(
        .AW      (8),
        .DW      (8),
        .SRC_ADDR(0),
        .DST_ADDR(2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .done    (done),
        .DataAddr(DataAddr),
        .ReadMem (ReadMem),
        .MemWrite(MemWrite),
        .DataIn  (DataIn),
        .DataOut (DataOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign DataOut = mem[DataAddr];

    always @(posedge clk) begin
        if (MemWrite === 1'b1) begin
            mem[DataAddr] <= DataIn;
            wr_cnt <= wr_cnt + 1;
            if (DataAddr < 8'd2) src_wr_cnt <= src_wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Value of the half float times 256, truncated toward zero, clamped to 16 bits.
    function automatic logic [15:0] ref_fix(input logic [15:0] f);
        int  e;
        int  iv;
        real v;
        e = int'(f[14:10]);
        if (e == 0) return 16'h0000;
        if (e == 31) return f[15] ? 16'h8000 : 16'h7FFF;
        v = 1024.0 + real'(f[9:0]);
        for (int i = 17; i < e; i++) v = v * 2.0;
        for (int i = e; i < 17; i++) v = v / 2.0;
        iv = $rtoi(v);
        if (f[15]) iv = -iv;
        if (iv > 32767) iv = 32767;
        if (iv < -32768) iv = -32768;
        return 16'(iv);
    endfunction

    // Expected start-to-done latency: 7 cycles plus the number of shift cycles.
    function automatic int ref_lat(input logic [15:0] f);
        int e;
        e = int'(f[14:10]);
        if (e == 0 || e >= 22 || (f[15] && f[14:0] == 15'h5800)) return 7;
        if (e > 17) return 7 + (e - 17);
        if (e == 17) return 8;
        return 7 + (((17 - e) > 12) ? 12 : (17 - e));
    endfunction

    // Run one conversion; start stays high for 'hold' cycles after the accept edge.
    task automatic run_conv(input logic [15:0] f, input int hold, output logic [15:0] res,
                            output int lat, output int writes, output logic done_acc);
        int w0;
        mem[0] = f[7:0];
        mem[1] = f[15:8];
        mem[2] = 8'hA5;
        mem[3] = 8'h5A;
        @(negedge clk);
        w0    = wr_cnt;
        start = 1'b1;
        @(posedge clk);
        #1;
        done_acc = done;
        if (hold == 0) start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat >= hold) start = 1'b0;
        end
        start  = 1'b0;
        res    = {mem[3], mem[2]};
        writes = wr_cnt - w0;
    endtask

    logic [15:0] dir_f   [13];
    logic [15:0] dir_exp [13];

    initial begin
        logic [15:0] res;
        logic [15:0] f;
        logic        d_acc;
        int          lat;
        int          writes;
        int          w0;

        pass_cnt   = 0;
        total_cnt  = 0;
        wr_cnt     = 0;
        src_wr_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        dir_f   = '{16'h3C00, 16'hC200, 16'h57FF, 16'hD800, 16'h5800, 16'h7C00, 16'hFE00,
                    16'h1C00, 16'h9C00, 16'h1800, 16'h0000, 16'h8000, 16'h03FF};
        dir_exp = '{16'h0100, 16'hFD00, 16'h7FF0, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000,
                    16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

        reset = 1'b0;
        start = 1'b0;
        #12;
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_memwrite", 32'(MemWrite), 32'd0);
        chk("rst_readmem", 32'(ReadMem), 32'd0);
        chk("rst_addr", 32'(DataAddr), 32'd0);
        chk("rst_datain", 32'(DataIn), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // +1.0: exact latency, write pulse count, done low after accept.
        run_conv(16'h3C00, 0, res, lat, writes, d_acc);
        chk("one_res", 32'(res), 32'h0100);
        chk("one_lat", 32'(lat), 32'd9);
        chk("one_writes", 32'(writes), 32'd2);
        chk("one_done_acc", 32'(d_acc), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_held_idle", 32'(done), 32'd1);

        // Directed values, traps and truncation boundaries.
        for (int i = 0; i < 13; i++) begin
            run_conv(dir_f[i], 0, res, lat, writes, d_acc);
            chk($sformatf("dir_res_%h", dir_f[i]), 32'(res), 32'(dir_exp[i]));
            chk($sformatf("dir_lat_%h", dir_f[i]), 32'(lat), 32'(ref_lat(dir_f[i])));
            chk($sformatf("dir_acc_%h", dir_f[i]), 32'(d_acc), 32'd0);
        end

        // Longest shift path: e=1 shifts right 12 times.
        run_conv(16'h0400, 0, res, lat, writes, d_acc);
        chk("e1_lat", 32'(lat), 32'd19);
        chk("e1_res", 32'(res), 32'h0000);

        // Reset asserted while shifting aborts the conversion.
        mem[0] = 8'h00;
        mem[1] = 8'h04;
        mem[2] = 8'hA5;
        mem[3] = 8'h5A;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        w0 = wr_cnt;
        #3;
        reset = 1'b0;
        #1;
        chk("abort_memwrite", 32'(MemWrite), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("abort_no_writes", 32'(wr_cnt - w0), 32'd0);
        chk("abort_done_low", 32'(done), 32'd0);
        chk("abort_dst", 32'({mem[3], mem[2]}), 32'h5AA5);

        run_conv(16'h3C00, 0, res, lat, writes, d_acc);
        chk("post_abort_res", 32'(res), 32'h0100);

        // Start held high for 5 busy cycles: no restart, one result.
        run_conv(16'hC200, 5, res, lat, writes, d_acc);
        chk("hold_res", 32'(res), 32'hFD00);
        chk("hold_lat", 32'(lat), 32'd8);
        chk("hold_writes", 32'(writes), 32'd2);
        repeat (25) @(posedge clk);
        #1;
        chk("hold_no_restart", 32'(done), 32'd1);

        // Back-to-back random conversions.
        for (int i = 0; i < 256; i++) begin
            f = 16'($urandom());
            chk("b2b_done_before", 32'(done), 32'd1);
            run_conv(f, 0, res, lat, writes, d_acc);
            chk($sformatf("rnd_res_%h", f), 32'(res), 32'(ref_fix(f)));
            chk($sformatf("rnd_lat_%h", f), 32'(lat), 32'(ref_lat(f)));
        end

        chk("src_never_written", 32'(src_wr_cnt), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
